// File: rtl/dmac_src_stream_req_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmac_src_stream_req_ctrl                                        |
// | Function : Transfer sequencer for the AXI-stream source data mover.        |
// |            Accepts one descriptor, issues the per-transfer request, then   |
// |            advances request_id once per 16-beat burst under a credit limit |
// |            against response_id, and reports completion once every burst   |
// |            has been retired by the source.                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmac_src_stream_req_ctrl #(
  parameter int C_ID_WIDTH     = 3,
  parameter int C_LENGTH_WIDTH = 24
) (
  input  logic                      s_axis_aclk,
  input  logic                      s_axis_reset,

  input  logic                      ctrl_enable,
  output logic                      ctrl_enabled,

  input  logic                      xfer_valid,
  output logic                      xfer_ready,
  input  logic [C_LENGTH_WIDTH-1:0] xfer_length,
  input  logic                      xfer_sync_on_user,
  output logic                      xfer_done,
  output logic                      xfer_aborted,

  output logic                      src_enable,
  input  logic                      src_enabled,
  output logic                      src_req_valid,
  input  logic                      src_req_ready,
  output logic [3:0]                src_req_last_burst_length,
  output logic                      src_req_sync_on_user,

  output logic [C_ID_WIDTH-1:0]     request_id,
  input  logic [C_ID_WIDTH-1:0]     response_id,
  output logic                      eot
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BURST = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                    state;
  // Bursts still to issue after the current one; all-ones length gives the
  // full 2^(C_LENGTH_WIDTH-4) bursts without needing an extra counter bit.
  logic [C_LENGTH_WIDTH-5:0] burst_remain;
  // Remembers that the transfer was cut short by a disable.
  logic                      abort_pending;

  logic [C_ID_WIDTH-1:0]     next_id;
  logic                      credit;
  logic                      drain_done;

  // Next id slot wraps naturally; credit stops request_id from lapping response_id.
  assign next_id    = request_id + 1'b1;
  assign credit     = (next_id != response_id);
  // An aborted transfer also waits for the source itself to shut down.
  assign drain_done = (response_id == request_id) && (!abort_pending || !src_enabled);

  // Descriptor acceptance and activity status are direct functions of state/inputs.
  assign xfer_ready   = (state == ST_IDLE) && ctrl_enable && src_enabled;
  assign ctrl_enabled = src_enabled || (state != ST_IDLE);

  // Transfer sequencing state machine with registered outputs.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_reset) begin
      state                     <= ST_IDLE;
      burst_remain              <= '0;
      abort_pending             <= 1'b0;
      src_enable                <= 1'b0;
      src_req_valid             <= 1'b0;
      src_req_last_burst_length <= 4'd0;
      src_req_sync_on_user      <= 1'b0;
      request_id                <= '0;
      eot                       <= 1'b0;
      xfer_done                 <= 1'b0;
      xfer_aborted              <= 1'b0;
    end else begin
      src_enable   <= ctrl_enable;
      xfer_done    <= 1'b0;
      xfer_aborted <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (xfer_valid && xfer_ready) begin
            burst_remain              <= xfer_length[C_LENGTH_WIDTH-1:4];
            src_req_last_burst_length <= xfer_length[3:0];
            src_req_sync_on_user      <= xfer_sync_on_user;
            src_req_valid             <= 1'b1;
            abort_pending             <= 1'b0;
            state                     <= ST_REQ;
          end
        end

        ST_REQ: begin
          // The request stays up until accepted even if disabled meanwhile.
          if (!ctrl_enable) begin
            abort_pending <= 1'b1;
          end
          if (src_req_ready) begin
            src_req_valid <= 1'b0;
            state         <= (abort_pending || !ctrl_enable) ? ST_DRAIN : ST_BURST;
          end
        end

        ST_BURST: begin
          if (!ctrl_enable) begin
            abort_pending <= 1'b1;
            state         <= ST_DRAIN;
          end else if (credit) begin
            request_id <= next_id;
            eot        <= (burst_remain == '0);
            if (burst_remain == '0) begin
              state <= ST_DRAIN;
            end else begin
              burst_remain <= burst_remain - 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (drain_done) begin
            xfer_done     <= 1'b1;
            xfer_aborted  <= abort_pending;
            eot           <= 1'b0;
            abort_pending <= 1'b0;
            state         <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmac_src_stream_req_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmac_src_stream_req_ctrl                                     |
// | Function : Self-checking bench; a transfer-level reference model tracks    |
// |            bursts issued versus bursts required and is compared with the   |
// |            design every cycle, plus directed literal expectations.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dmac_src_stream_req_ctrl;
  localparam int IDW = 3;
  localparam int LW  = 24;
  localparam int NID = 1 << IDW;

  logic           clk = 1'b0;
  logic           rst;
  logic           ctrl_enable, ctrl_enabled;
  logic           xfer_valid, xfer_ready;
  logic [LW-1:0]  xfer_length;
  logic           xfer_sync_on_user, xfer_done, xfer_aborted;
  logic           src_enable;
  logic           src_enabled = 1'b0;
  logic           src_req_valid;
  logic           src_req_ready = 1'b0;
  logic [3:0]     src_req_last_burst_length;
  logic           src_req_sync_on_user;
  logic [IDW-1:0] request_id;
  logic [IDW-1:0] response_id = '0;
  logic           eot;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmac_src_stream_req_ctrl #(.C_ID_WIDTH(IDW), .C_LENGTH_WIDTH(LW)) dut (
    .s_axis_aclk               (clk),
    .s_axis_reset              (rst),
    .ctrl_enable               (ctrl_enable),
    .ctrl_enabled              (ctrl_enabled),
    .xfer_valid                (xfer_valid),
    .xfer_ready                (xfer_ready),
    .xfer_length               (xfer_length),
    .xfer_sync_on_user         (xfer_sync_on_user),
    .xfer_done                 (xfer_done),
    .xfer_aborted              (xfer_aborted),
    .src_enable                (src_enable),
    .src_enabled               (src_enabled),
    .src_req_valid             (src_req_valid),
    .src_req_ready             (src_req_ready),
    .src_req_last_burst_length (src_req_last_burst_length),
    .src_req_sync_on_user      (src_req_sync_on_user),
    .request_id                (request_id),
    .response_id               (response_id),
    .eot                       (eot)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  // Source emulation: 0 = retire instantly, 1 = frozen, 2 = random, 3 = one per cycle.
  int resp_mode = 0;
  int req_delay = 0;
  int rdy_cnt   = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      response_id   = '0;
      src_req_ready = 1'b0;
      src_enabled   = 1'b0;
      rdy_cnt       = 0;
    end else begin
      src_enabled = src_enable;
      case (resp_mode)
        0: response_id = request_id;
        1: ;
        default: if (response_id != request_id &&
                     (resp_mode == 3 || $urandom_range(0, 1) == 1))
                   response_id = response_id + 1'b1;
      endcase
      if (src_req_valid) begin
        if (rdy_cnt >= req_delay) src_req_ready = 1'b1;
        else begin src_req_ready = 1'b0; rdy_cnt++; end
      end else begin
        src_req_ready = 1'b0;
        rdy_cnt       = 0;
      end
    end
  end

  // Transfer-level model: how many bursts a transfer needs and how many are out.
  localparam int P_IDLE = 0, P_REQ = 1, P_BURST = 2, P_DRAIN = 3;
  int m_ph = P_IDLE, m_total = 0, m_issued = 0, m_id = 0, m_len = 0;
  bit m_eot, m_done, m_abrt, m_cut, m_srcen, m_sync;
  always @(posedge clk) begin
    if (rst) begin
      m_ph = P_IDLE; m_id = 0; m_len = 0; m_sync = 0;
      m_eot = 0; m_done = 0; m_abrt = 0; m_cut = 0; m_srcen = 0;
    end else begin
      m_done = 0; m_abrt = 0;
      case (m_ph)
        P_IDLE: if (xfer_valid && ctrl_enable && src_enabled) begin
          m_total  = int'(xfer_length) / 16 + 1;
          m_issued = 0;
          m_len    = int'(xfer_length) % 16;
          m_sync   = xfer_sync_on_user;
          m_cut    = 0;
          m_ph     = P_REQ;
        end
        P_REQ: begin
          if (!ctrl_enable) m_cut = 1;
          if (src_req_ready) m_ph = m_cut ? P_DRAIN : P_BURST;
        end
        P_BURST: begin
          if (!ctrl_enable) begin
            m_cut = 1; m_ph = P_DRAIN;
          end else if (((m_id + 1) % NID) != int'(response_id)) begin
            m_id = (m_id + 1) % NID;
            m_issued++;
            m_eot = (m_issued == m_total);
            if (m_issued == m_total) m_ph = P_DRAIN;
          end
        end
        default: if (int'(response_id) == m_id && (!m_cut || !src_enabled)) begin
          m_done = 1; m_abrt = m_cut; m_eot = 0; m_ph = P_IDLE;
        end
      endcase
      m_srcen = ctrl_enable;
    end
  end

  // Per-cycle comparison against the model plus observation statistics.
  bit             cmp_en = 0;
  int             incs = 0, eot_incs = 0, done_cnt = 0, abort_cnt = 0, vcnt = 0;
  bit             last_inc_eot = 0, seen_sync = 0;
  logic [3:0]     seen_len = '0;
  logic [IDW-1:0] prev_rid = '0;
  logic [IDW-1:0] prev_nxt;
  always @(posedge clk) begin
    #3;
    if (cmp_en) begin
      chk("request_id",   request_id,   m_id);
      chk("eot",          eot,          m_eot);
      chk("xfer_done",    xfer_done,    m_done);
      chk("xfer_aborted", xfer_aborted, m_abrt);
      chk("src_enable",   src_enable,   m_srcen);
      chk("src_req_valid", src_req_valid, m_ph == P_REQ);
      if (m_ph == P_REQ) begin
        chk("req_last_len", src_req_last_burst_length, m_len);
        chk("req_sync",     src_req_sync_on_user,      m_sync);
      end
      chk("xfer_ready",   xfer_ready,   m_ph == P_IDLE && ctrl_enable && src_enabled);
      chk("ctrl_enabled", ctrl_enabled, src_enabled || m_ph != P_IDLE);
      prev_nxt = prev_rid + 1'b1;
      if (!rst && request_id == prev_nxt) begin
        incs++;
        last_inc_eot = eot;
        if (eot) eot_incs++;
      end
      prev_rid = request_id;
      if (xfer_done) begin
        done_cnt++;
        if (xfer_aborted) abort_cnt++;
      end
      if (src_req_valid) begin
        vcnt++;
        seen_len  = src_req_last_burst_length;
        seen_sync = src_req_sync_on_user;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #4; end
  endtask

  task automatic send(input int len, input bit sync);
    int b = 0;
    xfer_length = LW'(len); xfer_sync_on_user = sync; xfer_valid = 1'b1;
    while (!xfer_ready && b < 200) begin cyc(1); b++; end
    chk("send_ready_timeout", xfer_ready, 1);
    cyc(1);
    xfer_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int b = 0;
    while (done_cnt == d0 && b < budget) begin cyc(1); b++; end
    chk("done_timeout", done_cnt != d0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, e0, a0, d0;
    bit dis;
    rst = 1'b1; ctrl_enable = 1'b0; xfer_valid = 1'b0;
    xfer_length = '0; xfer_sync_on_user = 1'b0;
    @(posedge clk); #4;
    cmp_en = 1;
    cyc(2);
    chk("rst_request_id", request_id, 0);
    chk("rst_req_valid",  src_req_valid, 0);
    chk("rst_eot",        eot, 0);
    chk("rst_done",       xfer_done, 0);
    chk("rst_src_enable", src_enable, 0);
    rst = 1'b0; ctrl_enable = 1'b1;
    cyc(3);

    // Single burst, instant retirement.
    resp_mode = 0; req_delay = 0;
    i0 = incs; e0 = eot_incs; a0 = abort_cnt; d0 = done_cnt;
    send(9, 0); wait_done(d0, 100);
    chk("t1_last_len", seen_len, 9);
    chk("t1_incs",     incs - i0, 1);
    chk("t1_eot_incs", eot_incs - e0, 1);
    chk("t1_abort",    abort_cnt - a0, 0);

    // Four bursts, eot only on the last.
    i0 = incs; e0 = eot_incs; d0 = done_cnt;
    send(63, 0); wait_done(d0, 100);
    chk("t2_incs",     incs - i0, 4);
    chk("t2_eot_incs", eot_incs - e0, 1);
    chk("t2_last_eot", last_inc_eot, 1);
    chk("t2_id",       request_id, 5);
    chk("t2_abort",    abort_cnt - a0, 0);

    // Credit stall at 2^IDW-1 outstanding, then release and wrap.
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(3);
    resp_mode = 1; i0 = incs; d0 = done_cnt;
    send(255, 0); cyc(30);
    chk("t3_stall_id",   request_id, 7);
    chk("t3_stall_incs", incs - i0, 7);
    resp_mode = 3; wait_done(d0, 300);
    chk("t3_incs",   incs - i0, 16);
    chk("t3_wrap_id", request_id, 0);

    // Sync flag with a slow request acceptance.
    resp_mode = 2; req_delay = 5; vcnt = 0; d0 = done_cnt;
    send(20, 1); wait_done(d0, 300);
    chk("t4_sync",     seen_sync, 1);
    chk("t4_last_len", seen_len, 4);
    chk("t4_valid_cycles", vcnt, 6);
    req_delay = 0;

    // Disable after three bursts.
    resp_mode = 0; i0 = incs; a0 = abort_cnt; d0 = done_cnt;
    send(127, 0);
    for (int b = 0; b < 100 && incs - i0 < 3; b++) cyc(1);
    ctrl_enable = 1'b0;
    wait_done(d0, 100);
    chk("t5_incs",  incs - i0, 3);
    chk("t5_abort", abort_cnt - a0, 1);
    ctrl_enable = 1'b1; cyc(3);

    // Reset in the middle of a burst sequence.
    resp_mode = 1; d0 = done_cnt;
    send(255, 0); cyc(10);
    rst = 1'b1; cyc(1);
    chk("t6_rst_id",    request_id, 0);
    chk("t6_rst_eot",   eot, 0);
    chk("t6_rst_valid", src_req_valid, 0);
    rst = 1'b0; cyc(1);
    chk("t6_no_done", done_cnt - d0, 0);
    resp_mode = 0; cyc(2);
    i0 = incs; a0 = abort_cnt; d0 = done_cnt;
    send(40, 0); wait_done(d0, 100);
    chk("t6_incs",  incs - i0, 3);
    chk("t6_abort", abort_cnt - a0, 0);

    // Randomized traffic with occasional disables.
    for (int n = 0; n < 25; n++) begin
      resp_mode = 2;
      req_delay = $urandom_range(0, 3);
      dis = ($urandom_range(0, 3) == 0);
      d0 = done_cnt;
      send(($urandom_range(0, 3) == 0) ? $urandom_range(0, 300) : $urandom_range(0, 47),
           1'($urandom_range(0, 1)));
      if (dis) begin
        cyc($urandom_range(0, 8));
        ctrl_enable = 1'b0;
      end
      wait_done(d0, 600);
      ctrl_enable = 1'b1;
      cyc($urandom_range(1, 3));
    end

    cyc(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmac_src_stream_req_ctrl.md
Name: dmac_src_stream_req_ctrl

Overview:
- Sequences transfers for the AXI-stream source data mover.
- Accepts one transfer descriptor (length in beats, sync-on-user flag) and hands the per-transfer request to the source.
- Advances request_id once per burst of up to 16 beats, subject to a credit limit against response_id, and flags end-of-transfer (eot) on the final burst.
- Reports completion once the source has retired every burst; drains cleanly on disable.

Parameters:
- C_ID_WIDTH, 3, width of request_id/response_id; max outstanding bursts = 2^C_ID_WIDTH-1
- C_LENGTH_WIDTH, 24, width of transfer length field (beats minus one)

Ports:
- s_axis_aclk  in  1  clock, shared with the source data mover
- s_axis_reset  in  1  synchronous, active-high reset
- ctrl_enable  in  1  software enable for the stream source
- ctrl_enabled  out  1  high while the controller or source is active
- xfer_valid  in  1  descriptor valid
- xfer_ready  out  1  descriptor accepted
- xfer_length  in  C_LENGTH_WIDTH  transfer length in beats minus one
- xfer_sync_on_user  in  1  first beat must carry s_axis_user[0]
- xfer_done  out  1  one-cycle pulse when transfer fully retired
- xfer_aborted  out  1  qualifies xfer_done: transfer cut short by disable
- src_enable  out  1  enable to source data mover
- src_enabled  in  1  source enabled status
- src_req_valid  out  1  per-transfer request to source
- src_req_ready  in  1  source accepts request
- src_req_last_burst_length  out  4  beats minus one of final burst (xfer_length[3:0])
- src_req_sync_on_user  out  1  registered xfer_sync_on_user
- request_id  out  C_ID_WIDTH  id of next burst slot offered to source
- response_id  in  C_ID_WIDTH  id of next burst the source will complete
- eot  out  1  current burst (id request_id-1 just issued) is last of transfer

Behaviour:
- Reset values: all outputs 0; request_id=0; state IDLE. Reset mid-transfer returns to IDLE immediately without xfer_done.
- src_enable = ctrl_enable registered. ctrl_enabled = src_enabled | (state != IDLE).
- States: IDLE, REQ, BURST, DRAIN.
- IDLE:
  - xfer_ready = ctrl_enable & src_enabled.
  - On xfer_valid & xfer_ready, latch length and sync flag; burst_remain = xfer_length >> 4 (width C_LENGTH_WIDTH-4); go to REQ.
- REQ:
  - src_req_valid=1; last_burst_length and sync_on_user held stable until src_req_ready.
  - On handshake go to BURST; src_req_valid drops the next cycle.
- BURST:
  - credit = (request_id + 1) != response_id, modulo 2^C_ID_WIDTH.
  - Each cycle with credit & ctrl_enable: request_id <= request_id+1 and eot <= (burst_remain==0).
  - If burst_remain==0, go to DRAIN; otherwise decrement burst_remain.
  - eot is updated in the same cycle as request_id and is held until the next increment.
- DRAIN:
  - Wait for response_id == request_id, then pulse xfer_done for one cycle and return to IDLE.
  - eot cleared on exit.
- Disable: ctrl_enable low in REQ or BURST stops further id increments and goes to DRAIN.
  - In REQ, src_req_valid is held until handshake, per valid/ready rules; then go to DRAIN without issuing ids.
  - Exit from DRAIN additionally requires src_enabled==0.
  - xfer_aborted=1 alongside xfer_done.
- Simultaneous xfer_valid and ctrl_enable falling in IDLE: xfer_ready is already low, so the descriptor is not taken.
- ID wrap: request_id wraps 2^C_ID_WIDTH-1 -> 0; the credit compare prevents request_id from lapping response_id.
- Max burst count: xfer_length all-ones gives 2^(C_LENGTH_WIDTH-4) bursts; the counter must not overflow.
- Latency: xfer handshake -> src_req_valid next cycle; src_req_ready -> first id increment next cycle if credit.

Test Plan:
- Single burst: xfer_length=9, response_id tracks instantly -> src_req_last_burst_length=9, request_id 0->1 once with eot=1, xfer_done one cycle after response_id=1.
- Multi-burst: xfer_length=63 -> request_id increments 4 times, eot=1 only on the 4th; xfer_done when response_id=4; no abort.
- Credit stall: C_ID_WIDTH=3, response_id frozen at 0, xfer_length=255 -> request_id stops at 7. Releasing response_id one per cycle resumes increments; total 16 bursts, wraps to 0.
- Sync flag: xfer_sync_on_user=1 -> src_req_sync_on_user=1 stable from src_req_valid until src_req_ready (ready delayed 5 cycles).
- Disable mid-transfer: xfer_length=127, ctrl_enable dropped after 3 ids -> no further increments. xfer_done and xfer_aborted pulse after response_id=3 and src_enabled=0.
- Reset in BURST: assert s_axis_reset -> next cycle request_id=0, all outputs 0, no xfer_done; a new descriptor after reset completes normally.
